fsm_memoria_adder: RTL and testbench

Top-level popcount engine for the mining datapath. Loads a message of `MESS_WIDTH` bits into an on-chip byte memory, one byte per clock, under control of a small FSM. It then reads the memory back sequentially and accumulates the number of set bits. The result is a `$clog2(MESS_WIDTH+1)`-bit count with a completion flag `fine`.

---
 rtl/fsm_memoria_adder_if.sv | 37 +++
 rtl/fsm_memoria_adder.sv | 107 ++++++++++
 tb/tb_fsm_memoria_adder.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/fsm_memoria_adder_if.sv
// Load/readback bus of the popcount engine: control inputs, status and result.
// OUT_W widens to 8+ADDR_W when BYTE_SUM_EN is defined.
interface fsm_memoria_adder_if #(
    parameter int MESS_WIDTH = 4096
);
    localparam int DEPTH  = MESS_WIDTH / 8;
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef BYTE_SUM_EN
    localparam int OUT_W  = 8 + ADDR_W;
`else
    localparam int OUT_W  = $clog2(MESS_WIDTH + 1);
`endif

    logic              start;
    logic [7:0]        dati;
    logic [ADDR_W-1:0] indirizzo_write;
    logic [1:0]        state;
    logic              we;
    logic              fine_scrittura;
    logic              fine_lettura;
    logic [ADDR_W-1:0] indirizzo_read;
    logic [7:0]        out_mem;
    logic [OUT_W-1:0]  out;
    logic              fine;

    modport master (
        output start, dati, indirizzo_write,
        input  state, we, fine_scrittura, fine_lettura,
        input  indirizzo_read, out_mem, out, fine
    );

    modport slave (
        input  start, dati, indirizzo_write,
        output state, we, fine_scrittura, fine_lettura,
        output indirizzo_read, out_mem, out, fine
    );
endinterface

// File: rtl/fsm_memoria_adder.sv
// Byte-memory popcount engine: load MESS_WIDTH bits, read back, count ones.
// Define BYTE_SUM_EN to accumulate byte values instead of popcounts.
module fsm_memoria_adder #(
    parameter int MESS_WIDTH = 4096
) (
    input logic               clk,
    input logic               reset,
    fsm_memoria_adder_if.slave bus
);
    localparam int DEPTH  = MESS_WIDTH / 8;
    localparam int ADDR_W = $clog2(DEPTH);
`ifdef BYTE_SUM_EN
    localparam int OUT_W  = 8 + ADDR_W;
`else
    localparam int OUT_W  = $clog2(MESS_WIDTH + 1);
`endif

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] WRITE = 2'd1;
    localparam logic [1:0] READ  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [7:0]        mem [DEPTH];
    logic [1:0]        state;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [OUT_W-1:0]  acc;
    logic [OUT_W-1:0]  incr;
    logic              fine;
    logic              rd_valid;
    logic              we;
    logic              last_wr;
    logic              last_rd;

    function automatic logic [3:0] ones(input logic [7:0] b);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'b000, b[i]};
        return n;
    endfunction

`ifdef BYTE_SUM_EN
    assign incr = OUT_W'(rd_data);
`else
    assign incr = OUT_W'(ones(rd_data));
`endif

    assign we      = (state == WRITE);
    assign last_wr = we && (bus.indirizzo_write == LAST);
    assign last_rd = (state == READ) && (rd_addr == LAST);

    always_ff @(posedge clk) begin
        if (we) mem[bus.indirizzo_write] <= bus.dati;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            rd_addr  <= '0;
            rd_data  <= '0;
            acc      <= '0;
            fine     <= 1'b0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (state == READ);
            if (rd_valid) acc <= acc + incr;
            // rd_valid falling: the last byte is being added now
            if (rd_valid && state != READ) fine <= 1'b1;
            unique case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state <= WRITE;
                        acc   <= '0;
                        fine  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (last_wr) begin
                        state   <= READ;
                        rd_addr <= '0;
                    end
                end
                READ: begin
                    rd_data <= mem[rd_addr];
                    if (last_rd) begin
                        state   <= DONE;
                        rd_addr <= '0;
                    end else begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.state          = state;
    assign bus.we             = we;
    assign bus.fine_scrittura = last_wr;
    assign bus.fine_lettura   = last_rd;
    assign bus.indirizzo_read = rd_addr;
    assign bus.out_mem        = rd_data;
    assign bus.out            = acc;
    assign bus.fine           = fine;
endmodule

// File: tb/tb_fsm_memoria_adder.sv
// Bench for fsm_memoria_adder: table of load patterns, random loads
// checked against a queue-free byte-array model, plus abort/restart cases.
module tb_fsm_memoria_adder;
    localparam int MW    = 4096;
    localparam int DEPTH = MW / 8;
    localparam int AW    = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset = 1'b0;

    fsm_memoria_adder_if #(.MESS_WIDTH(MW)) bus ();

    fsm_memoria_adder #(.MESS_WIDTH(MW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         pat;
        logic [7:0] c;
        int         exp_pop;
        int         exp_sum;
        bit         rd_start;
        int         abort_at;
    } vec_t;

    vec_t       tbl [6];
    logic [7:0] data [DEPTH];
    int         total = 0;
    int         bad = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int pat, input logic [7:0] c);
        for (int i = 0; i < DEPTH; i++) begin
            case (pat)
                2:       data[i] = 8'(i);
                4:       data[i] = 8'($urandom);
                default: data[i] = c;
            endcase
        end
    endtask

    function automatic int model();
        int s;
        s = 0;
        for (int i = 0; i < DEPTH; i++) begin
`ifdef BYTE_SUM_EN
            s += int'(data[i]);
`else
            s += $countones(data[i]);
`endif
        end
        return s;
    endfunction

    task automatic do_run(input int exp, input bit rd_start, input int abort_at);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("start_state", 32'(bus.state), 32'd1);
        chk("start_out", 32'(bus.out), 32'd0);
        chk("start_fine", 32'(bus.fine), 32'd0);
        for (int k = 0; k < DEPTH; k++) begin
            bus.indirizzo_write = AW'(k);
            bus.dati = data[k];
            #1;
            chk("wr_state", 32'(bus.state), 32'd1);
            chk("wr_we", 32'(bus.we), 32'd1);
            chk("wr_last", 32'(bus.fine_scrittura), 32'(k == DEPTH - 1));
            tick();
        end
        for (int c = DEPTH; c < 2 * DEPTH; c++) begin
            bus.start = rd_start && c >= 600 && c <= 610;
            #1;
            chk("rd_state", 32'(bus.state), 32'd2);
            chk("rd_we", 32'(bus.we), 32'd0);
            chk("rd_addr", 32'(bus.indirizzo_read), 32'(c - DEPTH));
            chk("rd_last", 32'(bus.fine_lettura), 32'(c == 2 * DEPTH - 1));
            if (c > DEPTH) chk("rd_data", 32'(bus.out_mem), 32'(data[c - DEPTH - 1]));
            if (c == abort_at) begin
                reset = 1'b0;
                tick();
                chk("abort_state", 32'(bus.state), 32'd0);
                chk("abort_out", 32'(bus.out), 32'd0);
                chk("abort_fine", 32'(bus.fine), 32'd0);
                chk("abort_raddr", 32'(bus.indirizzo_read), 32'd0);
                reset = 1'b1;
                bus.start = 1'b0;
                tick();
                chk("idle_hold", 32'(bus.state), 32'd0);
                return;
            end
            tick();
        end
        bus.start = 1'b0;
        chk("done_state", 32'(bus.state), 32'd3);
        chk("done_last_byte", 32'(bus.out_mem), 32'(data[DEPTH - 1]));
        chk("done_fine_early", 32'(bus.fine), 32'd0);
        tick();
        chk("fine", 32'(bus.fine), 32'd1);
        chk("out", 32'(bus.out), 32'(exp));
        tick();
        chk("fine_hold", 32'(bus.fine), 32'd1);
        chk("out_hold", 32'(bus.out), 32'(exp));
        chk("done_stay", 32'(bus.state), 32'd3);
    endtask

    initial begin
        tbl[0] = '{0, 8'hFF, 4096, 130560, 1'b0, -1};
        tbl[1] = '{1, 8'h00, 0, 0, 1'b0, -1};
        tbl[2] = '{2, 8'h00, 2048, 65280, 1'b0, -1};
        tbl[3] = '{0, 8'hFF, 4096, 130560, 1'b1, 700};
        tbl[4] = '{0, 8'hFF, 4096, 130560, 1'b0, -1};
        tbl[5] = '{3, 8'h0F, 2048, 7680, 1'b0, -1};

        bus.start = 1'b1;
        bus.dati = 8'h00;
        bus.indirizzo_write = '0;
        reset = 1'b0;
        tick();
        tick();
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_fine", 32'(bus.fine), 32'd0);
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_raddr", 32'(bus.indirizzo_read), 32'd0);
        bus.start = 1'b0;
        reset = 1'b1;
        tick();
        chk("idle_no_start", 32'(bus.state), 32'd0);

        for (int i = 0; i < 6; i++) begin
            fill(tbl[i].pat, tbl[i].c);
`ifdef BYTE_SUM_EN
            do_run(tbl[i].exp_sum, tbl[i].rd_start, tbl[i].abort_at);
`else
            do_run(tbl[i].exp_pop, tbl[i].rd_start, tbl[i].abort_at);
`endif
        end

        for (int r = 0; r < 3; r++) begin
            fill(4, 8'h00);
            do_run(model(), 1'b0, -1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
